// File: rtl/vtg_pkg.sv
// Shared types and constants for the vertical timing generator.
// Timing-set fields are VTG_MAX_W wide so that one packed struct serves
// any LINE_W up to 16; narrower line counts are zero-extended into it.
package vtg_pkg;

  localparam int VTG_MAX_W    = 16;
  localparam int VTG_SYNC_DEF = 2;
  localparam int VTG_BP_DEF   = 31;
  localparam int VTG_ACT_DEF  = 480;
  localparam int VTG_FP_DEF   = 11;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    BP,
    ACT,
    FP
  } vtg_state_e;

  typedef struct packed {
    logic [VTG_MAX_W-1:0] sync;
    logic [VTG_MAX_W-1:0] bp;
    logic [VTG_MAX_W-1:0] act;
    logic [VTG_MAX_W-1:0] fp;
  } vtg_timing_t;

endpackage

// File: rtl/vtg_cfg_shadow.sv
// Pending/active timing registers with valid/ready handshake.
// A config with any zero-length field is rejected with a one-cycle cfg_err.
// An accepted config sits in the pending register, holding cfg_ready low,
// until the FSM signals a frame boundary through 'apply'.
module vtg_cfg_shadow
  import vtg_pkg::*;
#(
  parameter int LINE_W   = 11,
  parameter int SYNC_DEF = VTG_SYNC_DEF,
  parameter int BP_DEF   = VTG_BP_DEF,
  parameter int ACT_DEF  = VTG_ACT_DEF,
  parameter int FP_DEF   = VTG_FP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [LINE_W-1:0]    cfg_sync,
  input  logic [LINE_W-1:0]    cfg_bp,
  input  logic [LINE_W-1:0]    cfg_act,
  input  logic [LINE_W-1:0]    cfg_fp,
  input  logic                 apply,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  output logic [VTG_MAX_W-1:0] len_sync,
  output logic [VTG_MAX_W-1:0] len_bp,
  output logic [VTG_MAX_W-1:0] len_act,
  output logic [VTG_MAX_W-1:0] len_fp
);

  localparam vtg_timing_t DEF_SET = '{
    sync: VTG_MAX_W'(SYNC_DEF),
    bp:   VTG_MAX_W'(BP_DEF),
    act:  VTG_MAX_W'(ACT_DEF),
    fp:   VTG_MAX_W'(FP_DEF)
  };

  vtg_timing_t pending;
  vtg_timing_t active;
  vtg_timing_t offered;
  logic        pend_vld;
  logic        offer;
  logic        any_zero;

  assign offered = '{
    sync: VTG_MAX_W'(cfg_sync),
    bp:   VTG_MAX_W'(cfg_bp),
    act:  VTG_MAX_W'(cfg_act),
    fp:   VTG_MAX_W'(cfg_fp)
  };

  assign offer    = cfg_valid && !pend_vld;
  assign any_zero = (cfg_sync == '0) || (cfg_bp == '0) ||
                    (cfg_act == '0) || (cfg_fp == '0);

  assign cfg_ready = !pend_vld;
  assign len_sync  = active.sync;
  assign len_bp    = active.bp;
  assign len_act   = active.act;
  assign len_fp    = active.fp;

  // Accept or reject offers; at a boundary promote pending into the active set.
  // Accept and promote are exclusive because offers are only taken with
  // nothing pending, so a same-cycle boundary always uses the older set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending  <= DEF_SET;
      active   <= DEF_SET;
      pend_vld <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= offer && any_zero;
      if (offer && !any_zero) begin
        pending  <= offered;
        pend_vld <= 1'b1;
      end else if (apply && pend_vld) begin
        active   <= pending;
        pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/v_timing_gen.sv
// Parametrised vertical timing generator: counts line_tick strobes through
// SYNC/BP/ACT/FP phases and drives registered v_sync, v_de, row and frame
// boundary pulses. Phase lengths come from vtg_cfg_shadow and change only
// at frame boundaries. LINE_W must not exceed 16.
// Optional feature: define VTG_FRAME_CNT_EN to add a 16-bit frame_cnt output.
module v_timing_gen
  import vtg_pkg::*;
#(
  parameter int   LINE_W   = 11,
  parameter int   SYNC_DEF = VTG_SYNC_DEF,
  parameter int   BP_DEF   = VTG_BP_DEF,
  parameter int   ACT_DEF  = VTG_ACT_DEF,
  parameter int   FP_DEF   = VTG_FP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              line_tick,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LINE_W-1:0] cfg_sync,
  input  logic [LINE_W-1:0] cfg_bp,
  input  logic [LINE_W-1:0] cfg_act,
  input  logic [LINE_W-1:0] cfg_fp,
  output logic              cfg_err,
  output logic              v_sync,
  output logic              v_de,
  output logic [LINE_W-1:0] row,
  output logic              frame_start,
  output logic              frame_end
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`endif
);

  vtg_state_e           state, state_n;
  logic [LINE_W-1:0]    lcnt, lcnt_n;
  logic [VTG_MAX_W-1:0] len_sync, len_bp, len_act, len_fp;
  logic [VTG_MAX_W-1:0] cur_len;
  logic                 last_line;
  logic                 apply;
  logic                 fs_n, fe_n;
  logic                 v_sync_n, v_de_n;
  logic [LINE_W-1:0]    row_n;

  vtg_cfg_shadow #(
    .LINE_W   (LINE_W),
    .SYNC_DEF (SYNC_DEF),
    .BP_DEF   (BP_DEF),
    .ACT_DEF  (ACT_DEF),
    .FP_DEF   (FP_DEF)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_sync  (cfg_sync),
    .cfg_bp    (cfg_bp),
    .cfg_act   (cfg_act),
    .cfg_fp    (cfg_fp),
    .apply     (apply),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .len_sync  (len_sync),
    .len_bp    (len_bp),
    .len_act   (len_act),
    .len_fp    (len_fp)
  );

  // Pick the length of the phase currently being counted.
  always_comb begin
    cur_len = len_sync;
    case (state)
      SYNC:    cur_len = len_sync;
      BP:      cur_len = len_bp;
      ACT:     cur_len = len_act;
      FP:      cur_len = len_fp;
      default: cur_len = len_sync;
    endcase
  end

  assign last_line = (VTG_MAX_W'(lcnt) == (cur_len - VTG_MAX_W'(1)));

  // Next-state, line counter, boundary pulses and output decode.
  always_comb begin
    state_n = state;
    lcnt_n  = lcnt;
    fs_n    = 1'b0;
    fe_n    = 1'b0;
    apply   = 1'b0;
    if (!en) begin
      state_n = IDLE;
      lcnt_n  = '0;
    end else if (line_tick) begin
      if (state == IDLE) begin
        state_n = SYNC;
        lcnt_n  = '0;
        fs_n    = 1'b1;
        apply   = 1'b1;
      end else if (last_line) begin
        lcnt_n = '0;
        case (state)
          SYNC:    state_n = BP;
          BP:      state_n = ACT;
          ACT:     state_n = FP;
          FP: begin
            state_n = SYNC;
            fe_n    = 1'b1;
            fs_n    = 1'b1;
            apply   = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end else begin
        lcnt_n = lcnt + LINE_W'(1);
      end
    end
    v_sync_n = (state_n == SYNC) ? SYNC_POL : ~SYNC_POL;
    v_de_n   = (state_n == ACT);
    row_n    = (state_n == ACT) ? lcnt_n : '0;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lcnt        <= '0;
      v_sync      <= ~SYNC_POL;
      v_de        <= 1'b0;
      row         <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state       <= state_n;
      lcnt        <= lcnt_n;
      v_sync      <= v_sync_n;
      v_de        <= v_de_n;
      row         <= row_n;
      frame_start <= fs_n;
      frame_end   <= fe_n;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Free-running frame counter, wrapping naturally at 0xFFFF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (fs_n) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_v_timing_gen.sv
// Directed self-checking bench for v_timing_gen (default parameters).
// Lines arrive every 10 clocks; outputs are sampled on the falling edge
// right after each line_tick. Honours VTG_FRAME_CNT_EN when defined.
module tb_v_timing_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        line_tick;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [10:0] cfg_sync, cfg_bp, cfg_act, cfg_fp;
  logic        cfg_err;
  logic        v_sync;
  logic        v_de;
  logic [10:0] row;
  logic        frame_start;
  logic        frame_end;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_compared;
  int n_mismatched;

  int exp_de[8];
  int exp_row[8];
  int exp_vs[8];
  int exp_fe[8];

  v_timing_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .line_tick   (line_tick),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_sync    (cfg_sync),
    .cfg_bp      (cfg_bp),
    .cfg_act     (cfg_act),
    .cfg_fp      (cfg_fp),
    .cfg_err     (cfg_err),
    .v_sync      (v_sync),
    .v_de        (v_de),
    .row         (row),
    .frame_start (frame_start),
    .frame_end   (frame_end)
`ifdef VTG_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] act,
                              input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_cfg(input int s, input int b, input int a, input int f);
    cfg_sync = 11'(s);
    cfg_bp   = 11'(b);
    cfg_act  = 11'(a);
    cfg_fp   = 11'(f);
  endtask

  // One line period; ends on the falling edge just after the tick edge.
  task automatic apply_stimulus(input logic with_cfg);
    repeat (9) @(negedge clk);
    line_tick = 1'b1;
    cfg_valid = with_cfg;
    @(negedge clk);
    line_tick = 1'b0;
    cfg_valid = 1'b0;
  endtask

  // Config offer without a line tick; ends right after the handshake edge.
  task automatic offer_cfg();
    @(negedge clk);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic run_short(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(1'b0);
      check_output($sformatf("%s_de%0d", tag, i), v_de, exp_de[i]);
      check_output($sformatf("%s_row%0d", tag, i), row, exp_row[i]);
      check_output($sformatf("%s_vs%0d", tag, i), v_sync, exp_vs[i]);
      check_output($sformatf("%s_fe%0d", tag, i), frame_end, exp_fe[i]);
    end
  endtask

  initial begin
    int sync_lines, de_lines, fe_seen, exp_r, row_bad, last_row;
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b0;
    en        = 1'b0;
    line_tick = 1'b0;
    cfg_valid = 1'b0;
    set_cfg(0, 0, 0, 0);

    // Reset values
    repeat (3) @(negedge clk);
    check_output("rst_vsync", v_sync, 1);
    check_output("rst_de", v_de, 0);
    check_output("rst_row", row, 0);
    check_output("rst_fs", frame_start, 0);
    check_output("rst_fe", frame_end, 0);
    check_output("rst_err", cfg_err, 0);
    check_output("rst_ready", cfg_ready, 1);
    rst = 1'b1;
    en  = 1'b1;

    // Default 524-line frame
    sync_lines = 0; de_lines = 0; fe_seen = 0; exp_r = 0; row_bad = 0;
    last_row = 0;
    for (int i = 1; i <= 525; i++) begin
      apply_stimulus(1'b0);
      if (i == 1) check_output("first_fs", frame_start, 1);
      if (i <= 524) begin
        if (v_sync == 1'b0) sync_lines++;
        if (v_de) begin
          de_lines++;
          if (row != 11'(exp_r)) row_bad++;
          exp_r++;
          last_row = int'(row);
        end else if (row != 11'd0) begin
          row_bad++;
        end
        if (frame_end) fe_seen++;
      end else begin
        check_output("def_fe_525", frame_end, 1);
        check_output("def_fs_525", frame_start, 1);
      end
    end
    check_output("def_sync_lines", sync_lines, 2);
    check_output("def_de_lines", de_lines, 480);
    check_output("def_last_row", last_row, 479);
    check_output("def_row_bad", row_bad, 0);
    check_output("def_early_fe", fe_seen, 0);

    // Mid-frame offer of 1/2/4/1
    repeat (5) apply_stimulus(1'b0);
    check_output("mid_ready_pre", cfg_ready, 1);
    set_cfg(1, 2, 4, 1);
    offer_cfg();
    check_output("mid_ready_low", cfg_ready, 0);
    check_output("mid_err", cfg_err, 0);
    fe_seen = 0;
    for (int i = 1; i <= 519; i++) begin
      apply_stimulus(1'b0);
      if (i < 519 && frame_end) fe_seen++;
      if (i == 518) check_output("mid_ready_hold", cfg_ready, 0);
      if (i == 519) begin
        check_output("mid_fe", frame_end, 1);
        check_output("mid_ready_back", cfg_ready, 1);
      end
    end
    check_output("mid_early_fe", fe_seen, 0);

    exp_de  = '{0, 0, 1, 1, 1, 1, 0, 0};
    exp_row = '{0, 0, 0, 1, 2, 3, 0, 0};
    exp_vs  = '{1, 1, 1, 1, 1, 1, 1, 0};
    exp_fe  = '{0, 0, 0, 0, 0, 0, 0, 1};
    run_short("f8a", 8);

    // Rejected offer with act = 0
    set_cfg(3, 3, 0, 3);
    offer_cfg();
    check_output("rej_err", cfg_err, 1);
    check_output("rej_ready", cfg_ready, 1);
    @(negedge clk);
    check_output("rej_err_once", cfg_err, 0);
    run_short("f8b", 8);

    // Offer in the exact boundary cycle
    repeat (7) apply_stimulus(1'b0);
    set_cfg(1, 1, 2, 1);
    apply_stimulus(1'b1);
    check_output("bnd_fe", frame_end, 1);
    check_output("bnd_fs", frame_start, 1);
    check_output("bnd_ready", cfg_ready, 0);
    run_short("f8c", 8);
    check_output("bnd_ready_back", cfg_ready, 1);

    exp_de  = '{0, 1, 1, 0, 0, 0, 0, 0};
    exp_row = '{0, 0, 1, 0, 0, 0, 0, 0};
    exp_vs  = '{1, 1, 1, 1, 0, 0, 0, 0};
    exp_fe  = '{0, 0, 0, 0, 1, 0, 0, 0};
    set_cfg(3, 3, 200, 2);
    offer_cfg();
    check_output("big_ready", cfg_ready, 0);
    run_short("f5", 5);

    // Drop en in ACT at row 100
    repeat (106) apply_stimulus(1'b0);
    check_output("en_row100", row, 100);
    check_output("en_de_pre", v_de, 1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_output("en_de_off", v_de, 0);
    check_output("en_row_off", row, 0);
    check_output("en_vs_off", v_sync, 1);
    apply_stimulus(1'b0);
    check_output("en_off_fs", frame_start, 0);
    en = 1'b1;
    apply_stimulus(1'b0);
    check_output("en_back_fs", frame_start, 1);
    check_output("en_back_vs", v_sync, 0);
    check_output("en_back_fe", frame_end, 0);
    repeat (3) apply_stimulus(1'b0);
    check_output("sync3_vs", v_sync, 1);

    // Async reset in BP with a config pending
    apply_stimulus(1'b0);
    set_cfg(5, 5, 5, 5);
    offer_cfg();
    check_output("pre_rst_ready", cfg_ready, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_output("arst_ready", cfg_ready, 1);
    check_output("arst_vsync", v_sync, 1);
    check_output("arst_de", v_de, 0);
    check_output("arst_row", row, 0);
    check_output("arst_fs", frame_start, 0);
    check_output("arst_fe", frame_end, 0);
`ifdef VTG_FRAME_CNT_EN
    check_output("arst_fcnt", frame_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b0);
    check_output("rs_fs", frame_start, 1);
    check_output("rs_vs1", v_sync, 0);
`ifdef VTG_FRAME_CNT_EN
    check_output("rs_fcnt", frame_cnt, 1);
`endif
    apply_stimulus(1'b0);
    check_output("rs_vs2", v_sync, 0);
    apply_stimulus(1'b0);
    check_output("rs_vs3", v_sync, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
